fma_result_drain: RTL and testbench
===================================

# fma_result_drain

Output end of the FMA pipeline: absorbs results emitted by the final non-stalling pipeline register into a small FIFO and presents them to a valid/ready consumer. It also gates operation issue with credits, so the pipeline never produces more results than the FIFO can hold. It sits between the last pipeline stage and the result consumer, with `issue_ready` fed back to the operand issue logic.

## Interface
- `WIDTH`, 64, result word width in bits.
- `DEPTH`, 4, FIFO entries and initial credit count; power of two, ≥2.
- `CW`, $clog2(DEPTH+1), credit/occupancy counter width (derived, not overridden).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `issue_valid`  in  1  upstream requests issue of one FMA operation.
- `issue_ready`  out  1  credit available; issue fires on `issue_valid && issue_ready`.
- `res_valid`  in  1  result present at the final pipeline register this cycle (cannot stall).
- `res_data`  in  WIDTH  result word.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  WIDTH  head-of-FIFO word.
- `out_ready`  in  1  consumer accepts; pop fires on `out_valid && out_ready`.
- `credits`  out  CW  current credit count, 0..DEPTH.
- `overflow`  out  1  sticky error: a result was dropped, or a credit return would exceed DEPTH.

## Operation
- Credit counter:
  - Reset value DEPTH.
  - An issue fire decrements it; a pop fire increments it; both in the same cycle leave it unchanged.
  - `issue_ready` = (credits != 0), decoded from the registered count.
- Credit saturation: if a pop would raise credits above DEPTH (results pushed without a matching issue), credits hold at DEPTH and `overflow` sets.
- FIFO push on `res_valid`:
  - Accepted when occupancy < DEPTH, or when occupancy == DEPTH and a pop fires in the same cycle.
  - Otherwise the word is dropped, `overflow` sets, and pointers and occupancy are unchanged.
- Pop: read pointer advances and occupancy decrements. Push and pop in the same cycle leave occupancy unchanged.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is CW bits and distinguishes full from empty.
- `out_valid` = (occupancy != 0). `out_data` = storage[rd_ptr]. Both derive from registers only; there is no combinational path from `res_*` or `out_ready`.
- Once set, `overflow` clears only on `rst`.
- Reset (including mid-traffic):
  - Credits = DEPTH, occupancy 0, pointers 0.
  - All storage entries cleared to 0.
  - `out_valid` = 0, `out_data` = 0, `issue_ready` = 1, `overflow` = 0.
  - In-flight pipeline results arriving after reset are accepted as normal pushes. Upstream must reset the pipeline together with this block.

## Timing
- Push-to-visible latency is 1 cycle. A result with `res_valid` at edge N appears on `out_valid`/`out_data` after edge N; there is no fall-through in the same cycle.
- Credit return latency is 1 cycle. A pop at edge N raises `credits` and `issue_ready` after edge N.
- An issue at edge N with credits == 1 drops `issue_ready` to 0 after edge N.
- Full FIFO with `out_ready` held high sustains one push and one pop per cycle.
- Issue throughput is 1/cycle while credits > 0.
- `out_data` stays stable while `out_valid && !out_ready`.

## Structure
- `fma_pkg` holds the `FMA_WIDTH` (64) and `FMA_DRAIN_DEPTH` (4) constants and the counter-width helper.
- Sub-module `fma_result_fifo` contains storage, pointers, occupancy and push/pop/drop logic. It exposes `full`, `empty`, `pop_fire` and `drop`.
- The `fma_result_drain` top contains the credit counter, the `overflow` flag and the `issue_ready` decode.

## Test plan
- Reset, then idle: `credits`=4, `issue_ready`=1, `out_valid`=0, `out_data`=0, `overflow`=0.
- Four issues with `out_ready`=0, then results 0xA1..0xA4 on four consecutive cycles:
  - `credits` steps 3,2,1,0 and `issue_ready`=0 after the 4th issue.
  - FIFO full; `out_data`=0xA1.
  - Raising `out_ready` pops A1..A4 in order and `credits` returns to 4.
- Full FIFO, `res_valid` with 0xBB and `out_ready`=1 in the same cycle: head pops, 0xBB is accepted at the tail, occupancy stays 4, `overflow`=0.
- Full FIFO, `res_valid` with 0xCC and `out_ready`=0: 0xCC is dropped, `overflow`=1 and stays 1 until `rst`; FIFO contents are unchanged.
- Issue and pop in the same cycle at credits=2: credits remain 2.
- Pointer wrap: ten push/pop pairs on a depth-4 FIFO return the data in order.
- Assert `rst` with 3 entries queued: next cycle `out_valid`=0, `credits`=4, `out_data`=0.

Source files
------------

// File: rtl/fma_result_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fma_pkg
//  Description : Shared constants and a counter-width helper for the FMA
//                result drain (credit-gated output FIFO).
//  Revision    : 1.0  initial release
// ============================================================================
package fma_pkg;

    localparam int FMA_WIDTH       = 64;
    localparam int FMA_DRAIN_DEPTH = 4;

    // Width able to represent 0..depth inclusive (credits and occupancy).
    function automatic int fma_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : fma_result_drain_if
//  Description : Issue/result/output handshake bundle of the FMA result
//                drain. The slave modport is the drain itself, the master
//                modport is the surrounding pipeline and consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fma_result_drain_if
    import fma_pkg::*;
#(
    parameter int WIDTH = FMA_WIDTH,
    parameter int DEPTH = FMA_DRAIN_DEPTH
);
    localparam int CW = fma_cnt_width(DEPTH);

    logic             issue_valid;
    logic             issue_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    credits;
    logic             overflow;

    modport slave (
        input  issue_valid, res_valid, res_data, out_ready,
        output issue_ready, out_valid, out_data, credits, overflow
    );

    modport master (
        output issue_valid, res_valid, res_data, out_ready,
        input  issue_ready, out_valid, out_data, credits, overflow
    );

endinterface
`default_nettype wire

// File: rtl/fma_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fma_result_fifo
//  Description : Small FIFO absorbing non-stallable pipeline results. A push
//                into a full FIFO is accepted only if a pop frees the head
//                in the same cycle; otherwise the word is dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module fma_result_fifo
    import fma_pkg::*;
#(
    parameter int WIDTH = FMA_WIDTH,
    parameter int DEPTH = FMA_DRAIN_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop_req,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic                  pop_fire,
    output logic                  drop
);
    localparam int CW = fma_cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign pop_fire  = pop_req && !empty;
    assign w_push_ok = push && (!full || pop_fire);
    assign drop      = push && full && !pop_fire;
    assign head_data = r_mem[r_rd_ptr];

    // Storage, wrapping pointers and occupancy; drops leave all state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (pop_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, pop_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fma_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fma_result_drain
//  Description : Output end of the FMA pipeline. Buffers results in a small
//                FIFO and gates operation issue with credits so the pipeline
//                never produces more results than the FIFO can hold.
//  Revision    : 1.0  initial release
// ============================================================================
module fma_result_drain
    import fma_pkg::*;
#(
    parameter int WIDTH = FMA_WIDTH,
    parameter int DEPTH = FMA_DRAIN_DEPTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fma_result_drain_if.slave  bus
);
    localparam int CW = fma_cnt_width(DEPTH);

    logic [CW-1:0] r_credits;
    logic          r_overflow;
    logic          w_issue_fire;
    logic          w_pop_fire;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_credit_over;

    fma_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.res_valid),
        .push_data (bus.res_data),
        .pop_req   (bus.out_ready),
        .head_data (bus.out_data),
        .full      (w_full),
        .empty     (w_empty),
        .pop_fire  (w_pop_fire),
        .drop      (w_drop)
    );

    assign w_issue_fire  = bus.issue_valid && (r_credits != '0);
    // A pop with no matching issue at full credit means an unsolicited result.
    assign w_credit_over = w_pop_fire && !w_issue_fire && (r_credits == CW'(DEPTH));

    assign bus.issue_ready = (r_credits != '0);
    assign bus.out_valid   = !w_empty;
    assign bus.credits     = r_credits;
    assign bus.overflow    = r_overflow;

    // Credit counter with saturation at DEPTH, plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits  <= CW'(DEPTH);
            r_overflow <= 1'b0;
        end else begin
            if (w_issue_fire && !w_pop_fire) begin
                r_credits <= r_credits - CW'(1);
            end else if (w_pop_fire && !w_issue_fire && !w_credit_over) begin
                r_credits <= r_credits + CW'(1);
            end
            if (w_drop || w_credit_over) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Full flag is informational at this level; occupancy logic lives below.
    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_fma_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_result_drain
//  Description : Directed self-checking bench for fma_result_drain.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fma_result_drain;
    import fma_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fma_result_drain_if #(.WIDTH(64), .DEPTH(4)) bus ();

    fma_result_drain #(.WIDTH(64), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_data    = '0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Issue n operations then deliver n results base, base+1, ...
    task automatic fill(input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++) begin
            bus.issue_valid = 1'b1;
            step();
        end
        bus.issue_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = base + 64'(k);
            step();
        end
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        step();
        vectors++; if (bus.credits !== 3'd4) begin miscompares++; $display("FAIL reset_credits got %0d want 4", bus.credits); end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.issue_valid = 1'b1;
            step();
            vectors++; if (bus.credits !== 3'(3 - k)) begin miscompares++; $display("FAIL fill_credits got %0d want %0d", bus.credits, 3 - k); end
        end
        bus.issue_valid = 1'b0;
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL fill_issue_ready got %b want 0", bus.issue_ready); end
        for (int k = 0; k < 4; k++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 64'hA1 + 64'(k);
            if (k == 0) begin
                vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL no_fallthrough got %b want 0", bus.out_valid); end
            end
            step();
            vectors++; if (bus.out_data !== 64'hA1) begin miscompares++; $display("FAIL fill_head got %h want a1", bus.out_data); end
        end
        bus.res_valid = 1'b0;
        step();
        vectors++; if (bus.out_data !== 64'hA1 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_head got %h/%b want a1/1", bus.out_data, bus.out_valid); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = 64'hA1 + 64'(k);
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin miscompares++; $display("FAIL drain_data got %h/%b want %h/1", bus.out_data, bus.out_valid, exp); end
            step();
        end
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", bus.out_valid); end
        vectors++; if (bus.credits !== 3'd4 || bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL drain_credits got %0d/%b want 4/1", bus.credits, bus.issue_ready); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] want [4];
        want[0] = 64'hB2; want[1] = 64'hB3; want[2] = 64'hB4; want[3] = 64'hBB;
        do_reset();
        fill(4, 64'hB1);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'hBB;
        bus.out_ready = 1'b1;
        step();
        bus.res_valid = 1'b0;
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_overflow got %b want 0", bus.overflow); end
        vectors++; if (bus.credits !== 3'd1) begin miscompares++; $display("FAIL fullpp_credits got %0d want 1", bus.credits); end
        for (int k = 0; k < 4; k++) begin
            // Replace the credit consumed by the unmatched BB result.
            bus.issue_valid = (k == 0);
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== want[k]) begin miscompares++; $display("FAIL fullpp_data got %h/%b want %h/1", bus.out_data, bus.out_valid, want[k]); end
            step();
            if (k == 0) begin
                vectors++; if (bus.credits !== 3'd1) begin miscompares++; $display("FAIL issue_pop_same got %0d want 1", bus.credits); end
            end
        end
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fullpp_empty got %b want 0", bus.out_valid); end
        vectors++; if (bus.credits !== 3'd4 || bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_end got %0d/%b want 4/0", bus.credits, bus.overflow); end
    endtask

    task automatic test_drop();
        logic [63:0] exp;
        do_reset();
        fill(4, 64'hC1);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'hCC;
        step();
        bus.res_valid = 1'b0;
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL drop_overflow got %b want 1", bus.overflow); end
        vectors++; if (bus.out_data !== 64'hC1) begin miscompares++; $display("FAIL drop_head got %h want c1", bus.out_data); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = 64'hC1 + 64'(k);
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin miscompares++; $display("FAIL drop_data got %h/%b want %h/1", bus.out_data, bus.out_valid, exp); end
            step();
        end
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_empty got %b want 0", bus.out_valid); end
        vectors++; if (bus.overflow !== 1'b1 || bus.credits !== 3'd4) begin miscompares++; $display("FAIL drop_sticky got %b/%0d want 1/4", bus.overflow, bus.credits); end
        do_reset();
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL drop_cleared got %b want 0", bus.overflow); end
    endtask

    task automatic test_issue_pop_credits2();
        do_reset();
        fill(2, 64'hD1);
        vectors++; if (bus.credits !== 3'd2) begin miscompares++; $display("FAIL c2_setup got %0d want 2", bus.credits); end
        bus.issue_valid = 1'b1;
        bus.out_ready   = 1'b1;
        step();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        vectors++; if (bus.credits !== 3'd2) begin miscompares++; $display("FAIL c2_same_cycle got %0d want 2", bus.credits); end
        vectors++; if (bus.out_data !== 64'hD2) begin miscompares++; $display("FAIL c2_head got %h want d2", bus.out_data); end
    endtask

    task automatic test_credit_saturation();
        do_reset();
        bus.res_valid = 1'b1;
        bus.res_data  = 64'hE1;
        step();
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        vectors++; if (bus.credits !== 3'd4) begin miscompares++; $display("FAIL sat_credits got %0d want 4", bus.credits); end
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL sat_overflow got %b want 1", bus.overflow); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            exp = 64'h1000 + 64'(k * 3);
            bus.issue_valid = 1'b1;
            bus.res_valid   = 1'b1;
            bus.res_data    = exp;
            step();
            bus.issue_valid = 1'b0;
            bus.res_valid   = 1'b0;
            bus.out_ready   = 1'b1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin miscompares++; $display("FAIL wrap_data got %h/%b want %h/1", bus.out_data, bus.out_valid, exp); end
            step();
            bus.out_ready = 1'b0;
        end
        vectors++; if (bus.out_valid !== 1'b0 || bus.credits !== 3'd4 || bus.overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_end got %b/%0d/%b want 0/4/0", bus.out_valid, bus.credits, bus.overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(3, 64'hF1);
        vectors++; if (bus.credits !== 3'd1 || bus.out_data !== 64'hF1) begin miscompares++; $display("FAIL mid_setup got %0d/%h want 1/f1", bus.credits, bus.out_data); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.credits !== 3'd4 || bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL mid_credits got %0d/%b want 4/1", bus.credits, bus.issue_ready); end
        vectors++; if (bus.out_data !== 64'h0) begin miscompares++; $display("FAIL mid_out_data got %h want 0", bus.out_data); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_drop();
        test_issue_pop_credits2();
        test_credit_saturation();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
